emotion_argmax: RTL

Classifier head directly downstream of the final dense layer. Captures the eight signed 16-bit logits that the layer presents with its valid strobe, then scans them serially to find the winning emotion class, its logit, and the margin over the runner-up. It emits one registered result with a single-cycle valid pulse, plus a low-confidence flag. This block is the last datapath stage before the result/display logic.

---
 rtl/emotion_pkg.sv | 24 ++
 rtl/emotion_argmax_step.sv | 29 ++
 rtl/emotion_argmax.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/emotion_pkg.sv
// Shared types and constants for the emotion classifier head.
package emotion_pkg;

  localparam int unsigned LOGIT_W   = 16;
  localparam int unsigned N_CLASSES = 8;
  localparam int unsigned CLASS_W   = 3;

  localparam logic signed [LOGIT_W-1:0] LOGIT_MIN = 16'sh8000;
  localparam logic [CLASS_W-1:0]        LAST_IDX  = 3'd7;

  typedef enum logic [0:0] {
    IDLE,
    SCAN
  } state_e;

  // best >= second always holds, so the 17-bit difference is non-negative and fits in 16 bits.
  function automatic logic [LOGIT_W-1:0] calc_margin(input logic signed [LOGIT_W-1:0] best,
                                                      input logic signed [LOGIT_W-1:0] second);
    logic signed [LOGIT_W:0] diff;
    diff = {best[LOGIT_W-1], best} - {second[LOGIT_W-1], second};
    return diff[LOGIT_W-1:0];
  endfunction

endpackage

// File: rtl/emotion_argmax_step.sv
// One compare step of the serial argmax: folds element x into the running best/second pair.
module argmax_step
  import emotion_pkg::*;
(
  input  logic signed [LOGIT_W-1:0] x_i,
  input  logic        [CLASS_W-1:0] idx_i,
  input  logic signed [LOGIT_W-1:0] best_i,
  input  logic        [CLASS_W-1:0] best_idx_i,
  input  logic signed [LOGIT_W-1:0] second_i,
  output logic signed [LOGIT_W-1:0] best_o,
  output logic        [CLASS_W-1:0] best_idx_o,
  output logic signed [LOGIT_W-1:0] second_o
);

  // Strict compares: an equal later value never displaces the earlier winner.
  always_comb begin
    best_o     = best_i;
    best_idx_o = best_idx_i;
    second_o   = second_i;
    if (x_i > best_i) begin
      second_o   = best_i;
      best_o     = x_i;
      best_idx_o = idx_i;
    end else if (x_i > second_i) begin
      second_o = x_i;
    end
  end

endmodule

// File: rtl/emotion_argmax.sv
// Classifier head: captures eight logits, scans them serially, reports winner, logit and margin.
module emotion_argmax
  import emotion_pkg::*;
#(
  parameter int unsigned MARGIN_THRESH = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic signed [LOGIT_W-1:0] l0,
  input  logic signed [LOGIT_W-1:0] l1,
  input  logic signed [LOGIT_W-1:0] l2,
  input  logic signed [LOGIT_W-1:0] l3,
  input  logic signed [LOGIT_W-1:0] l4,
  input  logic signed [LOGIT_W-1:0] l5,
  input  logic signed [LOGIT_W-1:0] l6,
  input  logic signed [LOGIT_W-1:0] l7,
  input  logic                      valid_in,
  output logic        [CLASS_W-1:0] class_id,
  output logic signed [LOGIT_W-1:0] max_logit,
  output logic        [LOGIT_W-1:0] margin,
  output logic                      low_conf,
  output logic                      valid_out,
  output logic                      busy,
  output logic                      dropped
);

  state_e state_q, state_d;

  logic signed [LOGIT_W-1:0] logit_in    [N_CLASSES];
  logic signed [LOGIT_W-1:0] logit_buf_q [N_CLASSES];
  logic signed [LOGIT_W-1:0] logit_buf_d [N_CLASSES];

  logic        [CLASS_W-1:0] idx_q, idx_d;
  logic signed [LOGIT_W-1:0] best_q, best_d;
  logic        [CLASS_W-1:0] best_idx_q, best_idx_d;
  logic signed [LOGIT_W-1:0] second_q, second_d;

  logic        [CLASS_W-1:0] class_id_q, class_id_d;
  logic signed [LOGIT_W-1:0] max_logit_q, max_logit_d;
  logic        [LOGIT_W-1:0] margin_q, margin_d;
  logic                      low_conf_q, low_conf_d;
  logic                      valid_out_q, valid_out_d;

  logic signed [LOGIT_W-1:0] step_best;
  logic        [CLASS_W-1:0] step_best_idx;
  logic signed [LOGIT_W-1:0] step_second;

  assign logit_in[0] = l0;
  assign logit_in[1] = l1;
  assign logit_in[2] = l2;
  assign logit_in[3] = l3;
  assign logit_in[4] = l4;
  assign logit_in[5] = l5;
  assign logit_in[6] = l6;
  assign logit_in[7] = l7;

  argmax_step u_step (
    .x_i       (logit_buf_q[idx_q]),
    .idx_i     (idx_q),
    .best_i    (best_q),
    .best_idx_i(best_idx_q),
    .second_i  (second_q),
    .best_o    (step_best),
    .best_idx_o(step_best_idx),
    .second_o  (step_second)
  );

  always_comb begin
    state_d     = state_q;
    logit_buf_d = logit_buf_q;
    idx_d       = idx_q;
    best_d      = best_q;
    best_idx_d  = best_idx_q;
    second_d    = second_q;
    class_id_d  = class_id_q;
    max_logit_d = max_logit_q;
    margin_d    = margin_q;
    low_conf_d  = low_conf_q;
    valid_out_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (valid_in) begin
          logit_buf_d = logit_in;
          best_d      = l0;
          best_idx_d  = '0;
          second_d    = LOGIT_MIN;
          idx_d       = 3'd1;
          state_d     = SCAN;
        end
      end
      SCAN: begin
        best_d     = step_best;
        best_idx_d = step_best_idx;
        second_d   = step_second;
        idx_d      = idx_q + 3'd1;
        // The last element's compare result feeds the outputs directly.
        if (idx_q == LAST_IDX) begin
          class_id_d  = step_best_idx;
          max_logit_d = step_best;
          margin_d    = calc_margin(step_best, step_second);
          low_conf_d  = 32'(margin_d) < MARGIN_THRESH;
          valid_out_d = 1'b1;
          state_d     = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      for (int unsigned i = 0; i < N_CLASSES; i++) begin
        logit_buf_q[i] <= '0;
      end
      idx_q       <= '0;
      best_q      <= '0;
      best_idx_q  <= '0;
      second_q    <= '0;
      class_id_q  <= '0;
      max_logit_q <= '0;
      margin_q    <= '0;
      low_conf_q  <= 1'b0;
      valid_out_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      logit_buf_q <= logit_buf_d;
      idx_q       <= idx_d;
      best_q      <= best_d;
      best_idx_q  <= best_idx_d;
      second_q    <= second_d;
      class_id_q  <= class_id_d;
      max_logit_q <= max_logit_d;
      margin_q    <= margin_d;
      low_conf_q  <= low_conf_d;
      valid_out_q <= valid_out_d;
    end
  end

  assign class_id  = class_id_q;
  assign max_logit = max_logit_q;
  assign margin    = margin_q;
  assign low_conf  = low_conf_q;
  assign valid_out = valid_out_q;
  assign busy      = (state_q == SCAN);
  // Flags the cycle in which an input is being ignored.
  assign dropped   = valid_in && (state_q == SCAN);

endmodule
